// File: rtl/forward_converter_129_128_127_if.sv
// Valid/ready stream bundle for the {129,128,127} forward converter; out_err exists only with RNS_FWD_RANGE_CHECK_EN.
interface forward_converter_129_128_127_if;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_r1;
  logic [6:0]  out_r2;
  logic [6:0]  out_r3;
`ifdef RNS_FWD_RANGE_CHECK_EN
  logic        out_err;

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_r1, out_r2, out_r3, out_err
  );
  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_r1, out_r2, out_r3, out_err
  );
`else
  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_r1, out_r2, out_r3
  );
  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_r1, out_r2, out_r3
  );
`endif
endinterface

// File: rtl/forward_converter_129_128_127.sv
// Binary-to-RNS converter: 21-bit x -> (x mod 129, x mod 128, x mod 127); range flag with RNS_FWD_RANGE_CHECK_EN.
// Latency STAGES (1 or 2) cycles, one item per cycle.
// Backpressure: stalled stages hold; in_ready is combinational from out_ready through the stage chain.
module forward_converter_129_128_127 #(
  parameter int STAGES = 2
) (
  input logic clk,
  input logic rst,
  forward_converter_129_128_127_if.slave fc
);

  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("forward_converter_129_128_127: STAGES must be 1 or 2");
  end

  // End-around fold of a 9-bit chunk sum into 0..126 (127 aliases to 0)
  function automatic logic [6:0] fold127(input logic [8:0] s);
    logic [7:0] a;
    logic [6:0] b;
    a = {1'b0, s[6:0]} + {6'b0, s[8:7]};
    b = a[6:0] + {6'b0, a[7]};
    return (b == 7'd127) ? 7'd0 : b;
  endfunction

  function automatic logic [7:0] reduce129(input logic [9:0] t);
    logic [9:0] u;
    u = t;
    if (u >= 10'd129) u = u - 10'd129;
    if (u >= 10'd129) u = u - 10'd129;
    return 8'(u);
  endfunction

  logic [6:0] c0, c1, c2;
  logic [8:0] s_in;
  logic [9:0] t_in;

  assign c0   = fc.in_x[6:0];
  assign c1   = fc.in_x[13:7];
  assign c2   = fc.in_x[20:14];
  assign s_in = {2'b0, c0} + {2'b0, c1} + {2'b0, c2};
  // 2^7 = -1 and 2^14 = +1 mod 129; the +129 bias keeps t positive
  assign t_in = {3'b0, c0} + {3'b0, c2} + 10'd129 - {3'b0, c1};

`ifdef RNS_FWD_RANGE_CHECK_EN
  logic err_in;
  assign err_in = (fc.in_x >= 21'd2097024);
`endif

  if (STAGES == 2) begin : g_two
    logic       v1_q, v1_d, v2_q, v2_d;
    logic       load1, load2;
    logic [6:0] c0_q;
    logic [8:0] s_q;
    logic [9:0] t_q;
    logic [7:0] r1_q;
    logic [6:0] r2_q, r3_q;

    assign load2       = v1_q & (~v2_q | fc.out_ready);
    assign fc.in_ready = ~v1_q | load2;
    assign load1       = fc.in_valid & fc.in_ready;
    assign v1_d        = load1 | (v1_q & ~load2);
    assign v2_d        = load2 | (v2_q & ~fc.out_ready);

    always_ff @(posedge clk) begin
      if (rst) begin
        v1_q <= 1'b0;
        v2_q <= 1'b0;
        c0_q <= '0;
        s_q  <= '0;
        t_q  <= '0;
        r1_q <= '0;
        r2_q <= '0;
        r3_q <= '0;
      end else begin
        v1_q <= v1_d;
        v2_q <= v2_d;
        if (load1) begin
          c0_q <= c0;
          s_q  <= s_in;
          t_q  <= t_in;
        end
        if (load2) begin
          r1_q <= reduce129(t_q);
          r2_q <= c0_q;
          r3_q <= fold127(s_q);
        end
      end
    end

    assign fc.out_valid = v2_q;
    assign fc.out_r1    = r1_q;
    assign fc.out_r2    = r2_q;
    assign fc.out_r3    = r3_q;

`ifdef RNS_FWD_RANGE_CHECK_EN
    logic err1_q, err2_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        err1_q <= 1'b0;
        err2_q <= 1'b0;
      end else begin
        if (load1) err1_q <= err_in;
        if (load2) err2_q <= err1_q;
      end
    end
    assign fc.out_err = err2_q;
`endif
  end else begin : g_one
    logic       v_q, v_d;
    logic       load;
    logic [7:0] r1_q;
    logic [6:0] r2_q, r3_q;

    assign fc.in_ready = ~v_q | fc.out_ready;
    assign load        = fc.in_valid & fc.in_ready;
    assign v_d         = load | (v_q & ~fc.out_ready);

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q  <= 1'b0;
        r1_q <= '0;
        r2_q <= '0;
        r3_q <= '0;
      end else begin
        v_q <= v_d;
        if (load) begin
          r1_q <= reduce129(t_in);
          r2_q <= c0;
          r3_q <= fold127(s_in);
        end
      end
    end

    assign fc.out_valid = v_q;
    assign fc.out_r1    = r1_q;
    assign fc.out_r2    = r2_q;
    assign fc.out_r3    = r3_q;

`ifdef RNS_FWD_RANGE_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else if (load) err_q <= err_in;
    end
    assign fc.out_err = err_q;
`endif
  end

endmodule

// File: tb/tb_forward_converter_129_128_127.sv
// Directed and random checks of the forward converter against plain modulo arithmetic.
module tb_forward_converter_129_128_127;
  localparam int STAGES = 2;
  localparam int M      = 2097024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  forward_converter_129_128_127_if fc_if ();
  forward_converter_129_128_127 #(.STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .fc  (fc_if)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [20:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: residues straight from the % operator
  task automatic check_out(input string pfx, input int x);
    chk({pfx, ".valid"}, 32'(fc_if.out_valid), 1);
    chk({pfx, ".r1"}, 32'(fc_if.out_r1), 32'(x % 129));
    chk({pfx, ".r2"}, 32'(fc_if.out_r2), 32'(x % 128));
    chk({pfx, ".r3"}, 32'(fc_if.out_r3), 32'(x % 127));
`ifdef RNS_FWD_RANGE_CHECK_EN
    chk({pfx, ".err"}, 32'(fc_if.out_err), 32'(x >= M));
`endif
  endtask

  task automatic run_one(input string tag, input int x, input int e1, input int e2, input int e3,
                         input int eerr, output int o1, output int o2, output int o3);
    int lat;
    @(negedge clk);
    fc_if.in_valid  = 1'b1;
    fc_if.in_x      = 21'(x);
    fc_if.out_ready = 1'b1;
    #1 chk({tag, ".in_ready"}, 32'(fc_if.in_ready), 1);
    @(negedge clk);
    fc_if.in_valid = 1'b0;
    lat = 1;
    while (!fc_if.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(STAGES));
    chk({tag, ".r1"}, 32'(fc_if.out_r1), 32'(e1));
    chk({tag, ".r2"}, 32'(fc_if.out_r2), 32'(e2));
    chk({tag, ".r3"}, 32'(fc_if.out_r3), 32'(e3));
`ifdef RNS_FWD_RANGE_CHECK_EN
    chk({tag, ".err"}, 32'(fc_if.out_err), 32'(eerr));
`else
    if (eerr != 0) $display("note: %s expects a range flag the default build does not have", tag);
`endif
    o1 = int'(fc_if.out_r1);
    o2 = int'(fc_if.out_r2);
    o3 = int'(fc_if.out_r3);
    @(negedge clk);
    chk({tag, ".single_pulse"}, 32'(fc_if.out_valid), 0);
  endtask

  initial begin
    int o1, o2, o3, found, acc, idx;
    int items[3];
    logic stall_prev;
    logic [7:0] h1;
    logic [6:0] h2, h3;

    fc_if.in_valid  = 1'b0;
    fc_if.in_x      = '0;
    fc_if.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.out_valid", 32'(fc_if.out_valid), 0);
    chk("rst.r1", 32'(fc_if.out_r1), 0);
    chk("rst.r2", 32'(fc_if.out_r2), 0);
    chk("rst.r3", 32'(fc_if.out_r3), 0);
    chk("rst.in_ready", 32'(fc_if.in_ready), 1);
`ifdef RNS_FWD_RANGE_CHECK_EN
    chk("rst.err", 32'(fc_if.out_err), 0);
`endif

    // Directed values
    run_one("zero", 0, 0, 0, 0, 0, o1, o2, o3);
    run_one("x1000", 1000, 97, 104, 111, 0, o1, o2, o3);
    run_one("x127", 127, 127, 127, 0, 0, o1, o2, o3);
    run_one("m_minus_1", M - 1, 128, 127, 126, 0, o1, o2, o3);

    // CRT reconstruction of the M-1 residues must give back the operand
    found = -1;
    for (int k = 0; k < 16384; k++) begin
      int xr;
      xr = o2 + 128 * k;
      if (xr % 129 == o1 && xr % 127 == o3) begin
        found = xr;
        break;
      end
    end
    chk("crt_roundtrip", 32'(found), 32'(M - 1));

    run_one("top_alias", 2097151, 127, 127, 0, 1, o1, o2, o3);

    // Backpressure: two accepted, third held off, then drained in order
    for (int i = 0; i < 3; i++) items[i] = int'($urandom_range(0, 2097151));
    @(negedge clk);
    fc_if.out_ready = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      idx = (acc > 2) ? 2 : acc;
      fc_if.in_valid = 1'b1;
      fc_if.in_x     = 21'(items[idx]);
      #1;
      if (fc_if.in_ready) acc++;
    end
    @(negedge clk);
    idx = (acc > 2) ? 2 : acc;
    fc_if.in_x = 21'(items[idx]);
    #1;
    chk("bp.accepted", 32'(acc), 2);
    chk("bp.in_ready", 32'(fc_if.in_ready), 0);
    check_out("bp.hold", items[0]);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(negedge clk);
        fc_if.in_valid = 1'b0;
      end
      fc_if.out_ready = 1'b1;
      #1;
      check_out($sformatf("bp.item%0d", k), items[k]);
      if (k == 0) chk("bp.resume_ready", 32'(fc_if.in_ready), 1);
    end
    @(negedge clk);
    fc_if.in_valid = 1'b0;
    #1 chk("bp.drained", 32'(fc_if.out_valid), 0);

    // Reset with two items in flight
    @(negedge clk);
    fc_if.out_ready = 1'b0;
    fc_if.in_valid  = 1'b1;
    fc_if.in_x      = 21'($urandom_range(0, 2097151));
    @(negedge clk);
    fc_if.in_x      = 21'($urandom_range(0, 2097151));
    @(negedge clk);
    fc_if.in_valid  = 1'b0;
    #1 chk("rst_mid.loaded", 32'(fc_if.out_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid.out_valid", 32'(fc_if.out_valid), 0);
    chk("rst_mid.r1", 32'(fc_if.out_r1), 0);
    chk("rst_mid.r2", 32'(fc_if.out_r2), 0);
    chk("rst_mid.r3", 32'(fc_if.out_r3), 0);
    chk("rst_mid.in_ready", 32'(fc_if.in_ready), 1);
    rst = 1'b0;
    fc_if.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_mid.no_stale", 32'(fc_if.out_valid), 0);
    end

    // Random sweep with random backpressure and a scoreboard queue
    stall_prev = 1'b0;
    h1 = '0;
    h2 = '0;
    h3 = '0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (stall_prev) begin
        chk("stall.valid", 32'(fc_if.out_valid), 1);
        chk("stall.r1", 32'(fc_if.out_r1), 32'(h1));
        chk("stall.r2", 32'(fc_if.out_r2), 32'(h2));
        chk("stall.r3", 32'(fc_if.out_r3), 32'(h3));
      end
      fc_if.in_valid  = ($urandom_range(0, 3) != 0);
      fc_if.in_x      = ($urandom_range(0, 7) == 0) ? 21'($urandom_range(M - 4, 2097151))
                                                    : 21'($urandom_range(0, 2097151));
      fc_if.out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (fc_if.out_valid && fc_if.out_ready) begin
        chk("sb.nonempty", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) check_out("rand", int'(sb_q.pop_front()));
      end
      stall_prev = fc_if.out_valid && !fc_if.out_ready;
      h1 = fc_if.out_r1;
      h2 = fc_if.out_r2;
      h3 = fc_if.out_r3;
      if (fc_if.in_valid && fc_if.in_ready) sb_q.push_back(fc_if.in_x);
    end

    @(negedge clk);
    fc_if.in_valid  = 1'b0;
    fc_if.out_ready = 1'b1;
    for (int k = 0; k < 40 && sb_q.size() != 0; k++) begin
      #1;
      if (fc_if.out_valid) check_out("drain", int'(sb_q.pop_front()));
      @(negedge clk);
    end
    chk("drain.empty", 32'(sb_q.size()), 0);
    #1 chk("drain.idle", 32'(fc_if.out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
